// File: rtl/trigger_holdoff_gate_pkg.sv
// rtl/trigger_holdoff_gate_pkg.sv - shared state encoding and default widths
//
// Purpose: common definitions for the trigger holdoff gate and its counters.
//   state_e        FSM state encoding (IDLE=0, ARMED=1, HOLDOFF=2)
//   DEF_TS_W       default timestamp counter width
//   DEF_HOLD_W     default holdoff length width
//   DEF_CNT_W      default event / missed counter width
package trigger_holdoff_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam int DEF_TS_W   = 32;
  localparam int DEF_HOLD_W = 24;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/trigger_holdoff_gate_sat_counter.sv
// rtl/trigger_holdoff_gate_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc_i pulses, sticks at all-ones, clear has priority over increment.
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous reset, active-high
//   inc_i   in   increment request for this cycle
//   clr_i   in   zero the count (wins over inc_i)
//   cnt_o   out  current count, W bits
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trigger_holdoff_gate.sv
// rtl/trigger_holdoff_gate.sv - gated trigger with holdoff, arm/disarm, timestamp and counters
//
// Purpose: turns the edge detector's single-cycle pulse into an armed, rate-limited
// trigger. Each accepted trigger pulses trig_out/ts_valid one cycle later and latches
// the free-running timestamp; pulses arriving during holdoff are counted as missed.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous reset, active-high
//   trig_in     in   detection pulse
//   arm         in   IDLE -> ARMED request
//   disarm      in   any state -> IDLE, highest priority
//   auto_rearm  in   return to ARMED (1) or IDLE (0) when holdoff ends
//   holdoff     in   holdoff length in cycles, sampled at accept
//   clear_cnt   in   zero event_cnt and missed_cnt
//   trig_out    out  one-cycle pulse per accepted trigger
//   ts_out      out  timestamp of last accepted trigger
//   ts_valid    out  one-cycle pulse coincident with trig_out
//   armed       out  state == ARMED
//   busy        out  state == HOLDOFF
//   event_cnt   out  accepted triggers, saturating
//   missed_cnt  out  trig_in pulses dropped in HOLDOFF, saturating
module trigger_holdoff_gate
  import trigger_holdoff_gate_pkg::*;
#(
  parameter int TS_W   = DEF_TS_W,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trig_in,
  input  logic              arm,
  input  logic              disarm,
  input  logic              auto_rearm,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              clear_cnt,
  output logic              trig_out,
  output logic [TS_W-1:0]   ts_out,
  output logic              ts_valid,
  output logic              armed,
  output logic              busy,
  output logic [CNT_W-1:0]  event_cnt,
  output logic [CNT_W-1:0]  missed_cnt
);

  state_e            state_q;
  state_e            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   ts_out_q;
  logic              trig_out_q;
  logic              ts_valid_q;
  logic              armed_q;
  logic              busy_q;
  logic              accept;
  logic              missed;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    missed  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!disarm && arm) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_d = ST_IDLE;
        end else if (trig_in) begin
          accept = 1'b1;
          hold_d = holdoff;
          if (holdoff != '0) begin
            state_d = ST_HOLDOFF;
          end else if (auto_rearm) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (disarm) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          missed = trig_in;
          // Leaving on the count==1 cycle gives exactly 'holdoff' ignored cycles.
          // Treat 0 the same way so a corrupted counter cannot wedge the FSM.
          if (hold_q <= HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = auto_rearm ? ST_ARMED : ST_IDLE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      ts_q       <= '0;
      ts_out_q   <= '0;
      trig_out_q <= 1'b0;
      ts_valid_q <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ts_q       <= ts_q + TS_W'(1);
      trig_out_q <= accept;
      ts_valid_q <= accept;
      armed_q    <= (state_d == ST_ARMED);
      busy_q     <= (state_d == ST_HOLDOFF);
      if (accept) begin
        ts_out_q <= ts_q;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_event_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (accept),
    .clr_i (clear_cnt),
    .cnt_o (event_cnt)
  );

  sat_counter #(.W(CNT_W)) u_missed_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (missed),
    .clr_i (clear_cnt),
    .cnt_o (missed_cnt)
  );

  assign trig_out = trig_out_q;
  assign ts_valid = ts_valid_q;
  assign ts_out   = ts_out_q;
  assign armed    = armed_q;
  assign busy     = busy_q;

endmodule
